// File: rtl/crg_batch_engine.sv
// Batch controller for the correlated-random generator: issues a contiguous counter run
// to a counter-mode PRNG core and captures its in-order results. Optional abort: CRG_ABORT_EN.
module crg_batch_engine #(
  parameter int KEY_W    = 128,
  parameter int DOUT_W   = 256,
  parameter int DEPTH    = 256,
  parameter int CNT_W    = 32,
  parameter int PREFIX_W = 7,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_we,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                start,
  input  logic [AW:0]         batch_len,
  input  logic [CNT_W-1:0]    cnt_base,
  input  logic [PREFIX_W-1:0] prefix,
  output logic                busy,
  output logic                done,
  output logic                err_start,
  output logic [KEY_W-1:0]    core_key,
  output logic [PREFIX_W-1:0] core_prefix,
  output logic [CNT_W-1:0]    core_cnt,
  output logic                core_req,
  input  logic                core_vld,
  input  logic [DOUT_W-1:0]   core_dout,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [DOUT_W-1:0]   rd_data,
  output logic                rd_vld
`ifdef CRG_ABORT_EN
  ,
  input  logic                abort,
  output logic                aborted
`endif
);

  // Core handshake: no ready. Every cycle core_req is high is one request for core_cnt;
  // every cycle core_vld is high is one result, delivered in request order.
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_e;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [KEY_W-1:0]      key_q, key_d;
  logic [PREFIX_W-1:0]   prefix_q, prefix_d;
  logic [AW:0]           len_q, len_d;
  logic [CNT_W-1:0]      base_q, base_d;
  logic [AW:0]           issued_q, issued_d;
  logic [AW:0]           recv_q, recv_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DOUT_W-1:0]     rd_data_q, rd_data_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  wr_en;
  logic                  len_ok;
  logic [AW:0]           target;
  logic [DOUT_W-1:0]     mem_q [DEPTH];
`ifdef CRG_ABORT_EN
  logic                  abort_hit_q, abort_hit_d;
  logic                  aborted_q, aborted_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      prefix_q  <= '0;
      len_q     <= '0;
      base_q    <= '0;
      issued_q  <= '0;
      recv_q    <= '0;
      wptr_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
`ifdef CRG_ABORT_EN
      abort_hit_q <= 1'b0;
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      prefix_q  <= prefix_d;
      len_q     <= len_d;
      base_q    <= base_d;
      issued_q  <= issued_d;
      recv_q    <= recv_d;
      wptr_q    <= wptr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
`ifdef CRG_ABORT_EN
      abort_hit_q <= abort_hit_d;
      aborted_q   <= aborted_d;
`endif
    end
  end

  // Buffer is deliberately not reset; the read path samples it before this write lands.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= core_dout;
  end

  assign len_ok    = (batch_len != '0) && (batch_len <= LEN_MAX);
  assign rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  assign rd_vld_d  = rd_en;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    prefix_d = prefix_q;
    len_d    = len_q;
    base_d   = base_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    wptr_d   = wptr_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    target   = len_q;
`ifdef CRG_ABORT_EN
    abort_hit_d = abort_hit_q;
    aborted_d   = aborted_q;
    if (abort_hit_q) target = issued_q;
`endif
    if (state_q != ST_IDLE && core_vld) begin
      wr_en  = 1'b1;
      wptr_d = wptr_q + 1'b1;
      recv_d = recv_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (key_we) key_d = key_in;
        if (start) begin
          if (len_ok) begin
            len_d    = batch_len;
            base_d   = cnt_base;
            prefix_d = prefix;
            issued_d = '0;
            recv_d   = '0;
            wptr_d   = '0;
            state_d  = ST_ISSUE;
`ifdef CRG_ABORT_EN
            abort_hit_d = 1'b0;
            aborted_d   = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        err_d    = start;
        issued_d = issued_q + 1'b1;
        if (issued_q == len_q - 1'b1) state_d = ST_DRAIN;
`ifdef CRG_ABORT_EN
        if (abort) begin
          state_d     = ST_DRAIN;
          abort_hit_d = 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        err_d = start;
        if (recv_d == target) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
`ifdef CRG_ABORT_EN
          aborted_d = abort_hit_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    core_req = (state_q == ST_ISSUE);
    core_cnt = core_req ? (base_q + CNT_W'(issued_q)) : '0;
  end

  assign done        = done_q;
  assign err_start   = err_q;
  assign core_key    = key_q;
  assign core_prefix = prefix_q;
  assign rd_data     = rd_data_q;
  assign rd_vld      = rd_vld_q;
`ifdef CRG_ABORT_EN
  assign aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_crg_batch_engine.sv
// Directed bench for crg_batch_engine with an in-order, variable-latency core responder.
module tb_crg_batch_engine;
  localparam int KEY_W = 128, DOUT_W = 256, DEPTH = 256, CNT_W = 32, PREFIX_W = 7;
  localparam int AW = $clog2(DEPTH);
  localparam logic [KEY_W-1:0] KEY_A = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                key_we = 1'b0;
  logic [KEY_W-1:0]    key_in = '0;
  logic                start = 1'b0;
  logic [AW:0]         batch_len = '0;
  logic [CNT_W-1:0]    cnt_base = '0;
  logic [PREFIX_W-1:0] prefix = '0;
  logic                busy, done, err_start, core_req, rd_vld;
  logic [KEY_W-1:0]    core_key;
  logic [PREFIX_W-1:0] core_prefix;
  logic [CNT_W-1:0]    core_cnt;
  logic                core_vld = 1'b0;
  logic [DOUT_W-1:0]   core_dout = '0;
  logic                rd_en = 1'b0;
  logic [AW-1:0]       rd_addr = '0;
  logic [DOUT_W-1:0]   rd_data;
`ifdef CRG_ABORT_EN
  logic                abort = 1'b0;
  logic                aborted;
`endif

  int vectors = 0, fails = 0;
  int cyc = 0, t_start = 0, err_cnt = 0, rel = 0;
  int lat_min = 1, lat_max = 1, last_due = 0, nd = 0;
  logic [31:0] salt = '0;
  logic [DOUT_W-1:0] exp_q[$];
  logic [DOUT_W-1:0] rsp_q[$];
  int due_q[$];

  crg_batch_engine dut (
    .clk(clk), .rst(rst), .key_we(key_we), .key_in(key_in), .start(start),
    .batch_len(batch_len), .cnt_base(cnt_base), .prefix(prefix), .busy(busy),
    .done(done), .err_start(err_start), .core_key(core_key), .core_prefix(core_prefix),
    .core_cnt(core_cnt), .core_req(core_req), .core_vld(core_vld), .core_dout(core_dout),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld)
`ifdef CRG_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  // Clock / cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DOUT_W-1:0] resp(input logic [CNT_W-1:0] c, input logic [31:0] s);
    return {4{c ^ s, ~c}};
  endfunction

  // Core model: request seen in cycle m answers in cycle m+lat, never out of order.
  always @(negedge clk) begin
    if (rst) begin
      rsp_q.delete();
      due_q.delete();
      last_due  = 0;
      core_vld  = 1'b0;
      core_dout = '0;
    end else begin
      core_vld = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        core_vld  = 1'b1;
        core_dout = rsp_q.pop_front();
        void'(due_q.pop_front());
      end
      if (core_req === 1'b1) begin
        nd = cyc + int'($urandom_range(lat_max, lat_min));
        if (nd <= last_due) nd = last_due + 1;
        due_q.push_back(nd);
        rsp_q.push_back(resp(core_cnt, salt));
        last_due = nd;
      end
    end
  end

  always @(negedge clk) if (err_start === 1'b1) err_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks.
  task automatic chk(input string tag, input logic [DOUT_W-1:0] obs, input logic [DOUT_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_batch(input logic [AW:0] len, input logic [31:0] base, input logic [6:0] pfx);
    start = 1'b1; batch_len = len; cnt_base = base; prefix = pfx;
    t_start = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int r);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    r = cyc - t_start + 1;
  endtask

  task automatic rd_chk(input string tag, input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_vld"}, DOUT_W'(rd_vld), 1);
    chk(tag, rd_data, exp_q.pop_front());
  endtask

  task automatic bad_start(input string tag, input logic [AW:0] len);
    start = 1'b1; batch_len = len; cnt_base = 32'h77;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err"}, DOUT_W'(err_start), 1);
    chk({tag, "_busy"}, DOUT_W'(busy), 0);
  endtask

  initial begin
    logic [31:0] ce;
    // Reset state.
    @(negedge clk);
    chk("rst_busy", DOUT_W'(busy), 0);
    chk("rst_done", DOUT_W'(done), 0);
    chk("rst_err", DOUT_W'(err_start), 0);
    chk("rst_req", DOUT_W'(core_req), 0);
    chk("rst_key", DOUT_W'(core_key), 0);
    chk("rst_cnt", DOUT_W'(core_cnt), 0);
    chk("rst_rdvld", DOUT_W'(rd_vld), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: key load, batch of 4 at latency 10.
    key_we = 1'b1; key_in = KEY_A;
    @(negedge clk);
    key_we = 1'b0;
    chk("t1_key", DOUT_W'(core_key), DOUT_W'(KEY_A));
    lat_min = 10; lat_max = 10; salt = 32'h1111_0000;
    @(negedge clk);
    start_batch(4, 32'h10, 7'h55);
    chk("t1_busy", DOUT_W'(busy), 1);
    chk("t1_prefix", DOUT_W'(core_prefix), 7'h55);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      ce = 32'h10 + 32'(i);
      chk("t1_req", DOUT_W'(core_req), 1);
      chk("t1_cnt", DOUT_W'(core_cnt), DOUT_W'(ce));
    end
    @(negedge clk);
    chk("t1_req_off", DOUT_W'(core_req), 0);
    chk("t1_busy_drain", DOUT_W'(busy), 1);
    wait_done(40, rel);
    chk("t1_done_cycle", DOUT_W'(rel), 15);
    chk("t1_busy_done", DOUT_W'(busy), 0);
    @(negedge clk);
    chk("t1_done_pulse", DOUT_W'(done), 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(resp(32'h10 + 32'(i), 32'h1111_0000));
      rd_chk("t1_rd", i);
    end

    // 2: full-depth batch, counter wrap, read-first collision on address 0.
    lat_min = 1; lat_max = 1; salt = 32'h2222_0000;
    @(negedge clk);
    start_batch(9'd256, 32'hFFFF_FFFE, 7'h01);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      ce = 32'hFFFF_FFFE + 32'(i);
      chk("t2_req", DOUT_W'(core_req), 1);
      chk("t2_cnt", DOUT_W'(core_cnt), DOUT_W'(ce));
      if (i == 1) begin rd_en = 1'b1; rd_addr = '0; end
      if (i == 2) begin
        rd_en = 1'b0;
        chk("t2_rw_old", rd_data, resp(32'h10, 32'h1111_0000));
      end
    end
    @(negedge clk);
    chk("t2_req_off", DOUT_W'(core_req), 0);
    wait_done(40, rel);
    chk("t2_done_cycle", DOUT_W'(rel), 258);
    @(negedge clk);
    chk("t2_done_once", DOUT_W'(done), 0);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(resp(32'hFFFF_FFFE + 32'(i), 32'h2222_0000));
      rd_chk("t2_rd", i);
    end

    // 3: rejected starts and ignored key_we while busy.
    err_cnt = 0;
    @(negedge clk);
    bad_start("t3_len0", 9'd0);
    @(negedge clk);
    chk("t3_err_pulse", DOUT_W'(err_start), 0);
    bad_start("t3_len257", 9'd257);
    lat_min = 3; lat_max = 3; salt = 32'h3333_0000;
    @(negedge clk);
    start_batch(8, 32'h100, 7'h02);
    chk("t3_cnt0", DOUT_W'(core_cnt), 32'h100);
    @(negedge clk);
    chk("t3_cnt1", DOUT_W'(core_cnt), 32'h101);
    start = 1'b1; batch_len = 2; cnt_base = 32'h999; key_we = 1'b1; key_in = ~KEY_A;
    @(negedge clk);
    start = 1'b0; key_we = 1'b0;
    chk("t3_err_busy", DOUT_W'(err_start), 1);
    chk("t3_key_hold", DOUT_W'(core_key), DOUT_W'(KEY_A));
    for (int i = 2; i < 8; i++) begin
      if (i > 2) @(negedge clk);
      ce = 32'h100 + 32'(i);
      chk("t3_cnt", DOUT_W'(core_cnt), DOUT_W'(ce));
    end
    wait_done(40, rel);
    chk("t3_done_cycle", DOUT_W'(rel), 12);
    @(negedge clk);
    chk("t3_err_count", DOUT_W'(err_cnt), 3);
    chk("t3_key_final", DOUT_W'(core_key), DOUT_W'(KEY_A));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(resp(32'h100 + 32'(i), 32'h3333_0000));
      rd_chk("t3_rd", i);
    end

    // 4: variable latency 1..7.
    lat_min = 1; lat_max = 7; salt = 32'h4444_0000;
    @(negedge clk);
    start_batch(16, 32'h2000, 7'h03);
    wait_done(300, rel);
    chk("t4_done", DOUT_W'(done), 1);
    chk("t4_busy", DOUT_W'(busy), 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(resp(32'h2000 + 32'(i), 32'h4444_0000));
      rd_chk("t4_rd", i);
    end

    // 5: asynchronous reset mid-issue, then a short batch.
    lat_min = 2; lat_max = 2; salt = 32'h5555_0000;
    @(negedge clk);
    start_batch(16, 32'h3000, 7'h04);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", DOUT_W'(busy), 0);
    chk("t5_req", DOUT_W'(core_req), 0);
    chk("t5_done", DOUT_W'(done), 0);
    chk("t5_key", DOUT_W'(core_key), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start_batch(2, 32'h30, 7'h05);
    wait_done(40, rel);
    chk("t5_done_cycle", DOUT_W'(rel), 5);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(resp(32'h30 + 32'(i), 32'h5555_0000));
      rd_chk("t5_rd", i);
    end

`ifdef CRG_ABORT_EN
    // 6: abort after 20 requests.
    lat_min = 5; lat_max = 5; salt = 32'h6666_0000;
    @(negedge clk);
    start_batch(100, 32'h4000, 7'h06);
    for (int i = 1; i < 20; i++) @(negedge clk);
    chk("t6_req20", DOUT_W'(core_req), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_req_off", DOUT_W'(core_req), 0);
    chk("t6_busy", DOUT_W'(busy), 1);
    wait_done(60, rel);
    chk("t6_done_cycle", DOUT_W'(rel), 26);
    chk("t6_aborted", DOUT_W'(aborted), 1);
    @(negedge clk);
    chk("t6_aborted_hold", DOUT_W'(aborted), 1);
    exp_q.push_back(resp(32'h4013, 32'h6666_0000));
    rd_chk("t6_rd19", 19);
    exp_q.push_back(resp(32'h12, 32'h2222_0000));
    rd_chk("t6_rd20_stale", 20);
    start_batch(1, 32'h5000, 7'h07);
    chk("t6_aborted_clr", DOUT_W'(aborted), 0);
    wait_done(40, rel);
    chk("t6_done2_cycle", DOUT_W'(rel), 7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
